// File: rtl/vol_bar_render_if.sv
// vol_bar_render_if: theme colours, volume level and OLED pixel stream between driver and renderer
interface vol_bar_render_if;
   logic        frame_begin;
   logic        sample_pixel;
   logic [12:0] pixel_index;
   logic [3:0]  vol_level;
   logic [15:0] bor_col;
   logic [15:0] bg_col;
   logic [15:0] vol_col_top;
   logic [15:0] vol_col_mid;
   logic [15:0] vol_col_bot;
   logic        border_en;
   logic [15:0] pixel_data;
   logic        pixel_valid;
   logic [3:0]  peak_level;
   modport master (
      output frame_begin, sample_pixel, pixel_index, vol_level,
      output bor_col, bg_col, vol_col_top, vol_col_mid, vol_col_bot, border_en,
      input  pixel_data, pixel_valid, peak_level
   );
   modport slave (
      input  frame_begin, sample_pixel, pixel_index, vol_level,
      input  bor_col, bg_col, vol_col_top, vol_col_mid, vol_col_bot, border_en,
      output pixel_data, pixel_valid, peak_level
   );
endinterface

// File: rtl/vol_bar_render.sv
// vol_bar_render: renders a 15-segment volume bar with peak-hold marker onto a 96x64 OLED frame
module vol_bar_render #(
   parameter int WIDTH        = 96,
   parameter int HEIGHT       = 64,
   parameter int BAR_X0       = 40,
   parameter int BAR_X1       = 55,
   parameter int HOLD_FRAMES  = 30,
   parameter int DECAY_FRAMES = 4
) (
   input logic            clk,
   input logic            reset,
   vol_bar_render_if.slave bus
);
   typedef enum logic [1:0] {TRACK, HOLD, DECAY} pk_t;
   pk_t         st, nst;
   logic [3:0]  peak, peak_n, s_lvl, seg;
   logic [7:0]  hold, hold_n, decay, decay_n;
   logic [15:0] s_bor, s_bg, s_top, s_mid, s_bot, band, col;
   logic        s_ben, v1, in_bar, edge_px;
   logic [12:0] r, x1;
   logic [6:0]  q, y1;
   int          xi, yi;
   assign bus.peak_level = peak;
   assign xi = int'(x1);
   assign yi = int'(y1);
   // latch theme, level and border enable once per frame so nothing tears mid-frame
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s_lvl <= '0;
         s_bor <= '0;
         s_bg  <= '0;
         s_top <= '0;
         s_mid <= '0;
         s_bot <= '0;
         s_ben <= 1'b0;
      end else if (bus.frame_begin) begin
         s_lvl <= bus.vol_level;
         s_bor <= bus.bor_col;
         s_bg  <= bus.bg_col;
         s_top <= bus.vol_col_top;
         s_mid <= bus.vol_col_mid;
         s_bot <= bus.vol_col_bot;
         s_ben <= bus.border_en;
      end
   end
   // peak-hold state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         st    <= TRACK;
         peak  <= '0;
         hold  <= '0;
         decay <= '0;
      end else begin
         st    <= nst;
         peak  <= peak_n;
         hold  <= hold_n;
         decay <= decay_n;
      end
   end
   // per-frame peak update: track rises, hold for a while, then step down toward the level
   always_comb begin
      nst     = st;
      peak_n  = peak;
      hold_n  = hold;
      decay_n = decay;
      if (bus.frame_begin) begin
         if (bus.vol_level >= peak) begin
            nst     = TRACK;
            peak_n  = bus.vol_level;
            hold_n  = 8'(HOLD_FRAMES);
            decay_n = 8'(DECAY_FRAMES);
         end else if (hold != 8'd0) begin
            nst    = HOLD;
            hold_n = hold - 8'd1;
         end else if (decay <= 8'd1) begin
            peak_n  = peak - 4'd1;
            decay_n = 8'(DECAY_FRAMES);
            nst     = (peak_n == bus.vol_level) ? TRACK : DECAY;
         end else begin
            nst     = DECAY;
            decay_n = decay - 8'd1;
         end
      end
   end
   // restoring division of the raster index by the row width: q = row, r = column
   always_comb begin
      r = bus.pixel_index;
      q = '0;
      for (int i = 6; i >= 0; i--) begin
         if (r >= 13'(WIDTH << i)) begin
            r    = r - 13'(WIDTH << i);
            q[i] = 1'b1;
         end
      end
   end
   // stage 1: register column/row of the strobed index
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         v1 <= 1'b0;
         x1 <= '0;
         y1 <= '0;
      end else begin
         v1 <= bus.sample_pixel;
         if (bus.sample_pixel) begin
            x1 <= r;
            y1 <= q;
         end
      end
   end
   // find which bar segment (1..15, 0 = none) the row falls in; segment k spans rows H-2-3k..H-3k
   always_comb begin
      seg = '0;
      for (int k = 1; k <= 15; k++)
         if (yi >= HEIGHT - 2 - 3 * k && yi <= HEIGHT - 3 * k) seg = 4'(k);
   end
   // pick the pixel colour in priority order: off-screen, border, bar segment / peak marker, background
   always_comb begin
      in_bar  = xi >= BAR_X0 && xi <= BAR_X1 && seg != 4'd0;
      edge_px = xi == 0 || xi == WIDTH - 1 || yi == 0 || yi == HEIGHT - 1;
      band    = seg >= 4'd11 ? s_top : seg >= 4'd6 ? s_mid : s_bot;
      col     = yi >= HEIGHT                 ? s_bg  :
                s_ben && edge_px             ? s_bor :
                in_bar && seg <= s_lvl       ? band  :
                in_bar && seg == peak        ? s_top : s_bg;
   end
   // stage 2: emit the rendered pixel with a one-cycle valid
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bus.pixel_data  <= '0;
         bus.pixel_valid <= 1'b0;
      end else begin
         bus.pixel_valid <= v1;
         if (v1) bus.pixel_data <= col;
      end
   end
endmodule

// File: tb/tb_vol_bar_render.sv
// tb_vol_bar_render: directed tests of the volume bar renderer
module tb_vol_bar_render;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   tests = 0;
   int   fails = 0;
   vol_bar_render_if bus();
   vol_bar_render dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;

   task automatic get_px(input logic [12:0] idx, input logic fb, output logic [15:0] d, output logic v);
      @(negedge clk);
      bus.sample_pixel = 1'b1;
      bus.pixel_index  = idx;
      bus.frame_begin  = fb;
      @(negedge clk);
      bus.sample_pixel = 1'b0;
      bus.frame_begin  = 1'b0;
      @(posedge clk);
      #1;
      d = bus.pixel_data;
      v = bus.pixel_valid;
   endtask

   task automatic frame(input logic [3:0] lvl);
      @(negedge clk);
      bus.vol_level   = lvl;
      bus.frame_begin = 1'b1;
      @(negedge clk);
      bus.frame_begin = 1'b0;
   endtask

   task automatic test_reset;
      logic [15:0] d;
      logic v;
      repeat (2) @(negedge clk);
      tests++;
      if (bus.pixel_data !== 16'h0 || bus.pixel_valid !== 1'b0 || bus.peak_level !== 4'h0) begin
         fails++;
         $display("FAIL reset_state: data=%h valid=%b peak=%h expected 0000/0/0", bus.pixel_data, bus.pixel_valid, bus.peak_level);
      end
      reset = 1'b0;
      get_px(13'd0, 1'b0, d, v);
      tests++;
      if (d !== 16'h0000 || v !== 1'b1) begin
         fails++;
         $display("FAIL reset_first_px: data=%h valid=%b expected 0000/1", d, v);
      end
      @(posedge clk);
      #1;
      tests++;
      if (bus.pixel_valid !== 1'b0) begin
         fails++;
         $display("FAIL valid_one_cycle: valid=%b expected 0", bus.pixel_valid);
      end
   endtask

   task automatic test_border;
      logic [12:0] idx [6] = '{13'd0, 13'd95, 13'd6143, 13'd97, 13'd6048, 13'd6144};
      logic [15:0] exp [6] = '{16'h001F, 16'h001F, 16'h001F, 16'h0000, 16'h001F, 16'h0000};
      logic [15:0] d;
      logic v;
      bus.border_en = 1'b1;
      bus.bor_col   = 16'h001F;
      bus.bg_col    = 16'h0000;
      for (int i = 0; i < 6; i++) begin
         get_px(idx[i], i == 0, d, v);
         tests++;
         if (d !== exp[i] || v !== 1'b1) begin
            fails++;
            $display("FAIL border idx=%0d: data=%h valid=%b expected %h/1", idx[i], d, v, exp[i]);
         end
      end
   endtask

   task automatic test_bar;
      logic [12:0] idx [9] = '{13'd5896, 13'd4271, 13'd3887, 13'd4173, 13'd3991,
                               13'd5895, 13'd5912, 13'd1576, 13'd5935};
      logic [15:0] exp [9] = '{16'hFFFF, 16'h07E0, 16'h1234, 16'h07E0, 16'h07E0,
                               16'h1234, 16'h1234, 16'h1234, 16'h1234};
      logic [15:0] d;
      logic v;
      bus.border_en   = 1'b0;
      bus.bg_col      = 16'h1234;
      bus.vol_col_top = 16'hF800;
      bus.vol_col_mid = 16'h07E0;
      bus.vol_col_bot = 16'hFFFF;
      frame(4'd7);
      tests++;
      if (bus.peak_level !== 4'd7) begin
         fails++;
         $display("FAIL bar_peak: peak=%0d expected 7", bus.peak_level);
      end
      for (int i = 0; i < 9; i++) begin
         get_px(idx[i], 1'b0, d, v);
         tests++;
         if (d !== exp[i] || v !== 1'b1) begin
            fails++;
            $display("FAIL bar idx=%0d: data=%h valid=%b expected %h/1", idx[i], d, v, exp[i]);
         end
      end
   endtask

   task automatic test_back_to_back;
      logic [12:0] idx [3] = '{13'd5896, 13'd4271, 13'd3887};
      logic [15:0] exp [3] = '{16'hFFFF, 16'h07E0, 16'h1234};
      logic [15:0] d [6];
      logic v [6];
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         d[i] = bus.pixel_data;
         v[i] = bus.pixel_valid;
         bus.sample_pixel = i < 3;
         bus.pixel_index  = i < 3 ? idx[i] : 13'd0;
      end
      bus.sample_pixel = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tests++;
         if (d[i+2] !== exp[i] || v[i+2] !== 1'b1) begin
            fails++;
            $display("FAIL b2b slot=%0d: data=%h valid=%b expected %h/1", i, d[i+2], v[i+2], exp[i]);
         end
      end
      tests++;
      if (v[5] !== 1'b0) begin
         fails++;
         $display("FAIL b2b_tail_valid: valid=%b expected 0", v[5]);
      end
   endtask

   task automatic test_theme;
      logic [12:0] idx [5] = '{13'd5896, 13'd3887, 13'd5896, 13'd3887, 13'd8191};
      logic        fb  [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      logic [15:0] exp [5] = '{16'hFFFF, 16'h1234, 16'h00FF, 16'h5555, 16'h5555};
      logic [15:0] d;
      logic v;
      bus.vol_col_bot = 16'h00FF;
      bus.bg_col      = 16'h5555;
      for (int i = 0; i < 5; i++) begin
         get_px(idx[i], fb[i], d, v);
         tests++;
         if (d !== exp[i] || v !== 1'b1) begin
            fails++;
            $display("FAIL theme step=%0d: data=%h valid=%b expected %h/1", i, d, v, exp[i]);
         end
      end
   endtask

   task automatic test_peak;
      logic [15:0] d;
      logic v;
      logic [3:0] exp;
      frame(4'd12);
      tests++;
      if (bus.peak_level !== 4'd12) begin
         fails++;
         $display("FAIL peak_track: peak=%0d expected 12", bus.peak_level);
      end
      for (int f = 1; f <= 67; f++) begin
         frame(4'd3);
         if (f == 30 || f == 33 || f == 34 || f == 65 || f == 66 || f == 67) begin
            exp = f <= 33 ? 4'd12 : f == 34 ? 4'd11 : f == 65 ? 4'd4 : 4'd3;
            tests++;
            if (bus.peak_level !== exp) begin
               fails++;
               $display("FAIL peak frame=%0d: peak=%0d expected %0d", f, bus.peak_level, exp);
            end
         end
         if (f == 30) begin
            get_px(13'd2543, 1'b0, d, v);
            tests++;
            if (d !== 16'hF800 || v !== 1'b1) begin
               fails++;
               $display("FAIL peak_marker: data=%h valid=%b expected f800/1", d, v);
            end
         end
      end
      get_px(13'd2543, 1'b0, d, v);
      tests++;
      if (d !== 16'h5555 || v !== 1'b1) begin
         fails++;
         $display("FAIL marker_gone: data=%h valid=%b expected 5555/1", d, v);
      end
      get_px(13'd5231, 1'b0, d, v);
      tests++;
      if (d !== 16'h00FF || v !== 1'b1) begin
         fails++;
         $display("FAIL level3_seg3: data=%h valid=%b expected 00ff/1", d, v);
      end
   endtask

   task automatic test_reset_mid;
      logic [15:0] d;
      logic v;
      logic stale = 1'b0;
      @(negedge clk);
      bus.sample_pixel = 1'b1;
      bus.pixel_index  = 13'd0;
      @(negedge clk);
      bus.pixel_index  = 13'd97;
      @(posedge clk);
      #1;
      tests++;
      if (bus.pixel_valid !== 1'b1 || bus.pixel_data !== 16'h5555) begin
         fails++;
         $display("FAIL pre_reset_px: data=%h valid=%b expected 5555/1", bus.pixel_data, bus.pixel_valid);
      end
      #1;
      reset = 1'b1;
      #1;
      tests++;
      if (bus.pixel_valid !== 1'b0 || bus.peak_level !== 4'd0 || bus.pixel_data !== 16'h0) begin
         fails++;
         $display("FAIL async_reset: data=%h valid=%b peak=%0d expected 0000/0/0", bus.pixel_data, bus.pixel_valid, bus.peak_level);
      end
      @(negedge clk);
      bus.sample_pixel = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      repeat (4) begin
         @(posedge clk);
         #1;
         if (bus.pixel_valid !== 1'b0) stale = 1'b1;
      end
      tests++;
      if (stale !== 1'b0) begin
         fails++;
         $display("FAIL stale_after_reset: valid seen=%b expected 0", stale);
      end
      get_px(13'd0, 1'b0, d, v);
      tests++;
      if (d !== 16'h0000 || v !== 1'b1 || bus.peak_level !== 4'd0) begin
         fails++;
         $display("FAIL post_reset_px: data=%h valid=%b peak=%0d expected 0000/1/0", d, v, bus.peak_level);
      end
   endtask

   initial begin
      bus.frame_begin  = 1'b0;
      bus.sample_pixel = 1'b0;
      bus.pixel_index  = '0;
      bus.vol_level    = '0;
      bus.bor_col      = '0;
      bus.bg_col       = '0;
      bus.vol_col_top  = '0;
      bus.vol_col_mid  = '0;
      bus.vol_col_bot  = '0;
      bus.border_en    = 1'b0;
      test_reset;
      test_border;
      test_bar;
      test_back_to_back;
      test_theme;
      test_peak;
      test_reset_mid;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
